vga_scanout: RTL

VGA_SCANOUT -- requirements
Module: vga_scanout

---
 rtl/vga_scanout_pkg.sv | 51 +++++
 rtl/vga_scanout_if.sv | 34 +++
 rtl/vga_scanout_timing.sv | 52 +++++
 rtl/vga_scanout.sv | 90 +++++++++
 4 files changed

// File: rtl/vga_scanout_pkg.sv
`default_nettype none
// ============================================================================
// vga_scanout_pkg : 640x480@60 timing and 160x120 framebuffer constants
// Rev 1.0
// ============================================================================
package vga_scanout_pkg;

   localparam int H_CNT_W = 10;
   localparam int V_CNT_W = 10;

   localparam logic [H_CNT_W-1:0] H_VISIBLE    = 10'd640;
   localparam logic [H_CNT_W-1:0] H_FP         = 10'd16;
   localparam logic [H_CNT_W-1:0] H_SYNC       = 10'd96;
   localparam logic [H_CNT_W-1:0] H_BP         = 10'd48;
   localparam logic [H_CNT_W-1:0] H_TOTAL      = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam logic [H_CNT_W-1:0] H_SYNC_START = H_VISIBLE + H_FP;
   localparam logic [H_CNT_W-1:0] H_SYNC_END   = H_SYNC_START + H_SYNC;

   localparam logic [V_CNT_W-1:0] V_VISIBLE    = 10'd480;
   localparam logic [V_CNT_W-1:0] V_FP         = 10'd10;
   localparam logic [V_CNT_W-1:0] V_SYNC       = 10'd2;
   localparam logic [V_CNT_W-1:0] V_BP         = 10'd33;
   localparam logic [V_CNT_W-1:0] V_TOTAL      = V_VISIBLE + V_FP + V_SYNC + V_BP;
   localparam logic [V_CNT_W-1:0] V_SYNC_START = V_VISIBLE + V_FP;
   localparam logic [V_CNT_W-1:0] V_SYNC_END   = V_SYNC_START + V_SYNC;

   localparam int FB_WIDTH  = 160;
   localparam int FB_HEIGHT = 120;
   localparam int ADDR_W    = $clog2(FB_WIDTH * FB_HEIGHT);
   localparam int X_W       = $clog2(FB_WIDTH);
   localparam int Y_W       = $clog2(FB_HEIGHT);

   typedef logic [ADDR_W-1:0] fb_addr_t;

   typedef struct packed {
      logic hs_n;
      logic vs_n;
      logic blank_n;
   } sync_t;

   localparam sync_t SYNC_IDLE = '{hs_n: 1'b1, vs_n: 1'b1, blank_n: 1'b0};

   // y*160 + x built from shifts so no multiplier is inferred
   function automatic fb_addr_t fb_addr(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
      fb_addr_t w_y;
      w_y = fb_addr_t'(y);
      return (w_y << 7) + (w_y << 5) + fb_addr_t'(x);
   endfunction

endpackage
`default_nettype wire

// File: rtl/vga_scanout_if.sv
`default_nettype none
// ============================================================================
// vga_scanout_if : framebuffer read port and VGA DAC/sync bundle
// Rev 1.0
// ============================================================================
interface vga_scanout_if;
   import vga_scanout_pkg::*;

   logic [ADDR_W-1:0] rd_addr;
   logic [2:0]        rd_data;
   logic              frame_start;
   logic              VGA_CLK;
   logic              VGA_HS;
   logic              VGA_VS;
   logic              VGA_BLANK;
   logic              VGA_SYNC;
   logic [9:0]        VGA_R;
   logic [9:0]        VGA_G;
   logic [9:0]        VGA_B;

   modport master (
      output rd_addr, frame_start, VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK, VGA_SYNC,
             VGA_R, VGA_G, VGA_B,
      input  rd_data
   );

   modport slave (
      input  rd_addr, frame_start, VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK, VGA_SYNC,
             VGA_R, VGA_G, VGA_B,
      output rd_data
   );

endinterface
`default_nettype wire

// File: rtl/vga_scanout_timing.sv
`default_nettype none
// ============================================================================
// vga_timing : pixel enable, h/v counters and raw (undelayed) sync/blank decode
// Rev 1.0
// ============================================================================
module vga_timing
   import vga_scanout_pkg::*;
(
   input  logic           clock,
   input  logic           reset,
   output logic           pix_en,
   output logic [X_W-1:0] px_x,
   output logic [Y_W-1:0] px_y,
   output logic           hs_n,
   output logic           vs_n,
   output logic           visible,
   output logic           frame_start
);

   logic               r_pix_en;
   logic [H_CNT_W-1:0] r_h_cnt;
   logic [V_CNT_W-1:0] r_v_cnt;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_pix_en <= 1'b0;
         r_h_cnt  <= '0;
         r_v_cnt  <= '0;
      end else begin
         r_pix_en <= ~r_pix_en;
         if (r_pix_en) begin
            if (r_h_cnt == H_TOTAL - 1'b1) begin
               r_h_cnt <= '0;
               r_v_cnt <= (r_v_cnt == V_TOTAL - 1'b1) ? '0 : r_v_cnt + 1'b1;
            end else begin
               r_h_cnt <= r_h_cnt + 1'b1;
            end
         end
      end
   end

   // Each framebuffer pixel covers a 4x4 block of screen pixels
   assign px_x        = r_h_cnt[H_CNT_W-1:2];
   assign px_y        = r_v_cnt[Y_W+1:2];
   assign pix_en      = r_pix_en;
   assign hs_n        = !((r_h_cnt >= H_SYNC_START) && (r_h_cnt < H_SYNC_END));
   assign vs_n        = !((r_v_cnt >= V_SYNC_START) && (r_v_cnt < V_SYNC_END));
   assign visible     = (r_h_cnt < H_VISIBLE) && (r_v_cnt < V_VISIBLE);
   assign frame_start = r_pix_en && (r_h_cnt == '0) && (r_v_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/vga_scanout.sv
`default_nettype none
// ============================================================================
// vga_scanout : 160x120 3-bit framebuffer scanned out as 640x480 VGA
// Rev 1.0
// ============================================================================
module vga_scanout
   import vga_scanout_pkg::*;
#(
   parameter int    BITS_PER_COLOUR_CHANNEL = 1,
   parameter string MONOCHROME              = "FALSE"
)
(
   input  logic          clock,
   input  logic          reset,
   vga_scanout_if.master vga
);

   localparam int C_DAC_W = 10;
   localparam int C_REP   = C_DAC_W / BITS_PER_COLOUR_CHANNEL;

   logic           w_pix_en;
   logic [X_W-1:0] w_x;
   logic [Y_W-1:0] w_y;
   logic           w_hs_n;
   logic           w_vs_n;
   logic           w_visible;
   logic           w_frame_start;
   sync_t          w_sync;
   logic [2:0]     w_pix;

   logic           r_vga_clk;
   fb_addr_t       r_rd_addr;
   sync_t          r_s1;
   sync_t          r_s2;
   logic [2:0]     r_pix;

   vga_timing u_timing (
      .clock       (clock),
      .reset       (reset),
      .pix_en      (w_pix_en),
      .px_x        (w_x),
      .px_y        (w_y),
      .hs_n        (w_hs_n),
      .vs_n        (w_vs_n),
      .visible     (w_visible),
      .frame_start (w_frame_start)
   );

   generate
      if (MONOCHROME == "TRUE") begin : g_mono
         assign w_pix = {3{vga.rd_data[0]}};
      end else begin : g_colour
         assign w_pix = vga.rd_data;
      end
   endgenerate

   assign w_sync = '{hs_n: w_hs_n, vs_n: w_vs_n, blank_n: w_visible};

   // Stage 1 issues the RAM address, stage 2 takes the word back; sync rides along
   always_ff @(posedge clock) begin
      if (reset) begin
         r_vga_clk <= 1'b0;
         r_rd_addr <= '0;
         r_s1      <= SYNC_IDLE;
         r_s2      <= SYNC_IDLE;
         r_pix     <= '0;
      end else begin
         r_vga_clk <= w_pix_en;
         if (w_pix_en) begin
            r_rd_addr <= w_visible ? fb_addr(w_x, w_y) : '0;
            r_s1      <= w_sync;
            r_s2      <= r_s1;
            r_pix     <= r_s1.blank_n ? w_pix : 3'b000;
         end
      end
   end

   assign vga.rd_addr     = r_rd_addr;
   assign vga.frame_start = w_frame_start;
   assign vga.VGA_CLK     = r_vga_clk;
   assign vga.VGA_HS      = r_s2.hs_n;
   assign vga.VGA_VS      = r_s2.vs_n;
   assign vga.VGA_BLANK   = r_s2.blank_n;
   assign vga.VGA_SYNC    = 1'b1;
   assign vga.VGA_R       = {C_REP{r_pix[2]}};
   assign vga.VGA_G       = {C_REP{r_pix[1]}};
   assign vga.VGA_B       = {C_REP{r_pix[0]}};

endmodule
`default_nettype wire
